// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: command handshake and status bus between the front end (master)
// and the stack sequencer (slave).
interface stack_ctrl_if #(parameter int AW = 7, parameter int DW = 8);
    logic          cmd_valid;
    logic [2:0]    cmd;
    logic [DW-1:0] sw_data;
    logic          cmd_ready;
    logic [AW-1:0] spr;
    logic [AW-1:0] dar;
    logic [DW-1:0] dvr;
    logic          empty;
    logic          full;
    logic          err;
    modport master (output cmd_valid, cmd, sw_data,
                    input  cmd_ready, spr, dar, dvr, empty, full, err);
    modport slave  (input  cmd_valid, cmd, sw_data,
                    output cmd_ready, spr, dar, dvr, empty, full, err);
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequencer for the stack-calculator datapath driving a single-port sync RAM.
// Define STACK_CTRL_SAT_EN for saturating ADD/SUB; otherwise results wrap modulo 2**DW.
module stack_ctrl #(parameter int AW = 7, parameter int DW = 8) (
    input  logic          clk,
    input  logic          rst_n,
    stack_ctrl_if.slave   bus,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam logic [2:0] IDLE = 3'd0, PUSH_WR = 3'd1, RD_A = 3'd2, RD_B = 3'd3,
                           OP_WR = 3'd4, FETCH = 3'd5, LATCH = 3'd6;
    localparam logic [2:0] C_PUSH = 3'd0, C_POP = 3'd1, C_ADD = 3'd2, C_SUB = 3'd3,
                           C_TOP = 3'd4, C_CLEAR = 3'd5, C_DEC = 3'd6;
    logic [2:0]    state;
    logic [AW-1:0] spr, dar, top, second;
    logic [AW:0]   cnt;
    logic [DW-1:0] dvr, opnd, a_val, diff, result;
    logic [DW:0]   sum;
    logic          is_sub, err, accept, illegal, empty, full;
    assign top     = spr + AW'(1);
    assign second  = spr + AW'(2);
    assign empty   = cnt == '0;
    assign full    = cnt[AW];
    assign accept  = bus.cmd_valid && state == IDLE;
    assign illegal = (bus.cmd == C_PUSH && full) || (bus.cmd == C_POP && empty) ||
                     ((bus.cmd == C_ADD || bus.cmd == C_SUB) && cnt < (AW+1)'(2));
    // B is the deeper operand (read second), A the top of stack
    assign sum  = {1'b0, mem_rdata} + {1'b0, a_val};
    assign diff = mem_rdata - a_val;
`ifdef STACK_CTRL_SAT_EN
    assign result = is_sub ? (a_val > mem_rdata ? '0 : diff) : (sum[DW] ? '1 : sum[DW-1:0]);
`else
    assign result = is_sub ? diff : sum[DW-1:0];
`endif
    assign mem_we    = state == PUSH_WR || state == OP_WR;
    assign mem_addr  = state == PUSH_WR ? spr : state == RD_A ? top :
                       (state == RD_B || state == OP_WR) ? second : dar;
    assign mem_wdata = state == PUSH_WR ? opnd : state == OP_WR ? result : '0;
    assign bus.cmd_ready = state == IDLE;
    assign bus.spr   = spr;
    assign bus.dar   = dar;
    assign bus.dvr   = dvr;
    assign bus.empty = empty;
    assign bus.full  = full;
    assign bus.err   = err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            spr    <= '1;
            cnt    <= '0;
            dar    <= '0;
            dvr    <= '0;
            opnd   <= '0;
            a_val  <= '0;
            is_sub <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= accept && illegal;
            case (state)
                IDLE: if (accept && !illegal) begin
                    case (bus.cmd)
                        C_PUSH: begin
                            opnd  <= bus.sw_data;
                            state <= PUSH_WR;
                        end
                        C_POP: begin
                            spr   <= top;
                            cnt   <= cnt - (AW+1)'(1);
                            dar   <= second;
                            state <= FETCH;
                        end
                        C_ADD, C_SUB: begin
                            is_sub <= bus.cmd[0];
                            state  <= RD_A;
                        end
                        C_TOP: begin
                            dar   <= top;
                            state <= FETCH;
                        end
                        C_CLEAR: begin
                            spr <= '1;
                            cnt <= '0;
                            dar <= '0;
                            dvr <= '0;
                        end
                        C_DEC: begin
                            dar   <= dar - AW'(1);
                            state <= FETCH;
                        end
                        default: begin
                            dar   <= dar + AW'(1);
                            state <= FETCH;
                        end
                    endcase
                end
                PUSH_WR: begin
                    dar   <= spr;
                    spr   <= spr - AW'(1);
                    cnt   <= cnt + (AW+1)'(1);
                    state <= FETCH;
                end
                RD_A: state <= RD_B;
                RD_B: begin
                    a_val <= mem_rdata;
                    state <= OP_WR;
                end
                OP_WR: begin
                    spr   <= top;
                    cnt   <= cnt - (AW+1)'(1);
                    dar   <= second;
                    state <= FETCH;
                end
                FETCH: state <= LATCH;
                LATCH: begin
                    dvr   <= mem_rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: randomized command stream against an array-based stack model,
// plus the directed scenarios (arithmetic, empty/full limits, wrap, mid-command reset).
module tb_stack_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_we;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic [7:0] ram [128] = '{default: 8'h00};
    int         wr_cnt = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] ref_ram [128] = '{default: 8'h00};
    int         m_spr, m_cnt, m_dar, m_dvr;

    stack_ctrl_if #(.AW(7), .DW(8)) bus ();
    stack_ctrl #(.AW(7), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_spr = 127; m_cnt = 0; m_dar = 0; m_dvr = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_spr"}, 32'(bus.spr), 32'(m_spr));
        check({tag, "_dar"}, 32'(bus.dar), 32'(m_dar));
        check({tag, "_dvr"}, 32'(bus.dvr), 32'(m_dvr));
        check({tag, "_empty"}, 32'(bus.empty), 32'(m_cnt == 0));
        check({tag, "_full"}, 32'(bus.full), 32'(m_cnt == 128));
    endtask

    // Issue one command, compare handshake timing and results against the model.
    task automatic do_cmd(input logic [2:0] c, input logic [7:0] d);
        int rej, lat, exp_lat, exp_wr, wr0, a, b, r;
        rej = 0; exp_lat = 0; exp_wr = 0;
        case (c)
            3'd0: if (m_cnt == 128) rej = 1; else begin
                ref_ram[m_spr] = d; m_dar = m_spr; m_spr = (m_spr + 127) % 128;
                m_cnt++; exp_lat = 3; exp_wr = 1;
            end
            3'd1: if (m_cnt == 0) rej = 1; else begin
                m_dar = (m_spr + 2) % 128; m_spr = (m_spr + 1) % 128; m_cnt--; exp_lat = 2;
            end
            3'd2, 3'd3: if (m_cnt < 2) rej = 1; else begin
                a = int'(ref_ram[(m_spr + 1) % 128]);
                b = int'(ref_ram[(m_spr + 2) % 128]);
`ifdef STACK_CTRL_SAT_EN
                r = (c == 3'd2) ? ((b + a > 255) ? 255 : b + a) : ((a > b) ? 0 : b - a);
`else
                r = (c == 3'd2) ? (b + a) % 256 : (b - a + 256) % 256;
`endif
                ref_ram[(m_spr + 2) % 128] = 8'(r);
                m_dar = (m_spr + 2) % 128; m_spr = (m_spr + 1) % 128; m_cnt--;
                exp_lat = 5; exp_wr = 1;
            end
            3'd4: begin m_dar = (m_spr + 1) % 128; exp_lat = 2; end
            3'd5: begin m_spr = 127; m_cnt = 0; m_dar = 0; m_dvr = 0; end
            3'd6: begin m_dar = (m_dar + 127) % 128; exp_lat = 2; end
            default: begin m_dar = (m_dar + 1) % 128; exp_lat = 2; end
        endcase
        if (exp_lat > 0) m_dvr = int'(ref_ram[m_dar]);
        @(negedge clk);
        check("ready_idle", 32'(bus.cmd_ready), 32'd1);
        check("err_idle", 32'(bus.err), 32'd0);
        wr0 = wr_cnt;
        bus.cmd_valid = 1'b1; bus.cmd = c; bus.sw_data = d;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("err", 32'(bus.err), 32'(rej));
        lat = 0;
        while (!bus.cmd_ready && lat < 20) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd = 3'($urandom);
            bus.sw_data = 8'($urandom);
            lat++;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("writes", 32'(wr_cnt - wr0), 32'(exp_wr));
        check_state("post");
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd = '0; bus.sw_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check_state("rst");
        rst_n = 1'b1;

        do_cmd(3'd0, 8'h05);
        do_cmd(3'd0, 8'h03);
        check("tp_spr", 32'(bus.spr), 32'h7D);
        check("tp_dar", 32'(bus.dar), 32'h7E);
        check("tp_dvr", 32'(bus.dvr), 32'h03);
        do_cmd(3'd3, 8'h00);
        check("tp_sub", 32'(bus.dvr), 32'h02);
        check("tp_sub_ram", 32'(ram[127]), 32'h02);
        check("tp_sub_spr", 32'(bus.spr), 32'h7E);

        do_cmd(3'd5, 8'h00);
        do_cmd(3'd0, 8'hF0);
        do_cmd(3'd0, 8'h20);
        do_cmd(3'd2, 8'h00);
`ifdef STACK_CTRL_SAT_EN
        check("tp_add_ovf", 32'(bus.dvr), 32'hFF);
`else
        check("tp_add_ovf", 32'(bus.dvr), 32'h10);
`endif
        do_cmd(3'd5, 8'h00);
        do_cmd(3'd0, 8'h01);
        do_cmd(3'd0, 8'h02);
        do_cmd(3'd3, 8'h00);
`ifdef STACK_CTRL_SAT_EN
        check("tp_sub_unf", 32'(bus.dvr), 32'h00);
`else
        check("tp_sub_unf", 32'(bus.dvr), 32'hFF);
`endif
        do_cmd(3'd5, 8'h00);
        check("tp_clr_dvr", 32'(bus.dvr), 32'h00);
        do_cmd(3'd1, 8'h00);
        do_cmd(3'd2, 8'h00);
        check("tp_empty_spr", 32'(bus.spr), 32'h7F);

        for (int i = 0; i < 128; i++) do_cmd(3'd0, 8'($urandom));
        check("tp_full", 32'(bus.full), 32'd1);
        check("tp_full_dar", 32'(bus.dar), 32'h00);
        do_cmd(3'd0, 8'hAA);
        do_cmd(3'd6, 8'h00);
        check("tp_dec_wrap", 32'(bus.dar), 32'h7F);
        do_cmd(3'd7, 8'h00);
        check("tp_inc_wrap", 32'(bus.dar), 32'h00);
        do_cmd(3'd4, 8'h00);

        for (int i = 0; i < 400; i++) begin
            logic [2:0] c;
            c = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom);
            if (c == 3'd5 && $urandom_range(0, 3) != 0) c = 3'd4;
            do_cmd(c, 8'($urandom));
        end

        do_cmd(3'd5, 8'h00);
        do_cmd(3'd0, 8'h11);
        do_cmd(3'd0, 8'h22);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd = 3'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("opwr_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_we", 32'(mem_we), 32'd0);
        check("arst_ready", 32'(bus.cmd_ready), 32'd1);
        check_state("arst");
        @(negedge clk);
        rst_n = 1'b1;
        check("arst_ram", 32'(ram[126]), 32'h22);
        do_cmd(3'd6, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencer for the 128x8 stack-calculator datapath. Accepts one stack command at a time from the button/switch front end and drives the single-port synchronous RAM. Maintains the stack pointer (SPR), data address (DAR) and data value (DVR) registers, and reports empty/full/error status to the LED and display logic.

## Interface
- AW, 7, RAM address width; stack depth is 2**AW entries
- DW, 8, data width
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command strobe
- cmd  in  3  0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 TOP, 5 CLEAR, 6 DEC, 7 INC
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
- sw_data  in  DW  push operand, sampled at acceptance
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_addr is presented
- spr  out  AW  next free stack slot
- dar  out  AW  displayed address
- dvr  out  DW  displayed value, RAM[dar]
- empty  out  1  cnt == 0
- full  out  1  cnt == 2**AW
- err  out  1  one-cycle pulse on rejected command

## Operation
- Stack grows downward from 2**AW-1; spr = next free slot; top = spr+1; second = spr+2; all address arithmetic mod 2**AW. Occupancy cnt is AW+1 bits.
- States: IDLE, PUSH_WR, RD_A, RD_B, OP_WR, FETCH, LATCH.
- IDLE: on acceptance, decode cmd. Illegal cases consume the command, pulse err, change nothing else and stay in IDLE: PUSH when full; POP when empty; ADD/SUB when cnt < 2.
- PUSH -> PUSH_WR: mem_we=1, mem_addr=spr, mem_wdata=captured sw_data. Then dar<=spr, spr<=spr-1, cnt+1 -> FETCH.
- POP: spr<=spr+1, cnt-1, dar<=spr+2 (new top) -> FETCH. Data is not erased.
- ADD/SUB -> RD_A: addr=spr+1 -> RD_B: addr=spr+2, capture A=mem_rdata -> OP_WR: B=mem_rdata; write mem[spr+2] = B+A (ADD) or B-A (SUB), modulo 2**DW. Then spr<=spr+1, cnt-1, dar<=spr+2 -> FETCH.
- TOP: dar<=spr+1 -> FETCH. On empty stack, shows the slot above spr; no err.
- CLEAR: spr<=2**AW-1, cnt<=0, dar<=0, dvr<=0 -> IDLE. RAM is not erased.
- DEC/INC: dar<=dar-1 / dar+1 with wrap; no stack change -> FETCH.
- FETCH: mem_addr=dar, mem_we=0 -> LATCH: dvr<=mem_rdata -> IDLE.
- mem_we is asserted only in PUSH_WR and OP_WR.

## Timing
- Reset values: state IDLE, cmd_ready=1, spr=2**AW-1, cnt=0, dar=0, dvr=0, mem_we=0, mem_addr=0, mem_wdata=0, empty=1, full=0, err=0.
- Latency from the accepting edge until cmd_ready returns: PUSH 3, POP/TOP/DEC/INC 2, ADD/SUB 5, CLEAR 0, rejected 0. dvr updates on the final edge.
- err is high for exactly the cycle after the accepting edge.
- cmd_valid while busy is ignored, not queued. The front end holds or re-strobes.
- Reset asserted mid-command aborts immediately with mem_we=0 and reset values restored. A write already committed to RAM remains.
- cnt=2**AW: spr has wrapped back to 2**AW-1, and top=spr+1=0 is consistent. full and empty are derived from cnt only.

## Configuration
- STACK_CTRL_SAT_EN defined: ADD clamps to 2**DW-1 on carry; SUB clamps to 0 when A > B.
- Undefined: modulo-2**DW wrap for both ADD and SUB.

## Test plan
- Reset, PUSH 0x05, PUSH 0x03 -> spr=0x7D, dar=0x7E, dvr=0x03, cnt=2; each PUSH holds cmd_ready low for 3 cycles.
- From that state, SUB -> mem[0x7F]=0x02, spr=0x7E, dar=0x7F, dvr=0x02, 5-cycle busy. ADD instead gives 0x08.
- PUSH 0xF0, PUSH 0x20, ADD -> 0x10 without macro, 0xFF with STACK_CTRL_SAT_EN. Stack {0x01, 0x02}, SUB -> 0xFF or 0x00 respectively.
- On empty stack: POP, ADD -> err pulse each, spr=0x7F, dvr unchanged. After 128 PUSHes, full=1 and dar=0x00; a 129th PUSH -> err pulse, no RAM write.
- DEC at dar=0 -> dar=0x7F, dvr=RAM[0x7F]. INC at 0x7F -> dar=0x00. CLEAR -> spr=0x7F, dar=0, dvr=0, empty=1.
- Assert rst_n low during OP_WR -> mem_we drops asynchronously and all registers return to reset values. cmd_valid pulsed while busy -> ignored.
